// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - block refill/write-back initiator over the single-word main-memory protocol
// Optional per-word watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_burst_master #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int WORDS          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [WORDS*DATA_W-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [WORDS*DATA_W-1:0] resp_rdata,
    output logic                    resp_error,
    output logic                    busy,
    output logic                    mem_read_or_write,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_write_data,
    input  logic                    mem_done,
    input  logic [DATA_W-1:0]       mem_read_data
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam int BLK_W = WORDS * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_write;
    logic [ADDR_W-OFF_W-1:0]   r_base;
    logic [BLK_W-1:0]          r_wdata;
    logic [BLK_W-1:0]          r_buf;
    logic [BLK_W-1:0]          r_rdata;
    logic                      r_req_ready;
    logic                      r_busy;
    logic                      r_resp_valid;
    logic                      r_mem_rw;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [DATA_W-1:0]         r_mem_wdata;
    logic                      r_sync1;
    logic                      r_sync2;
    logic                      r_sync_q;

    logic                      w_done_evt;
    logic                      w_last;
    logic                      w_timeout;
    logic [BLK_W-1:0]          w_buf_next;
    logic                      w_unused_addr;

    assign w_done_evt    = r_sync2 & ~r_sync_q;
    assign w_last        = (r_idx == IDX_W'(WORDS - 1));
    assign w_unused_addr = ^req_addr[OFF_W-1:0];

    // The refill block is assembled in r_buf so resp_rdata keeps the previous block until completion.
    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[int'(r_idx)*DATA_W +: DATA_W] = mem_read_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_q <= 1'b0;
        end else begin
            r_sync1  <= mem_done;
            r_sync2  <= r_sync1;
            r_sync_q <= r_sync2;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_resp_error;

    assign w_timeout  = (r_state == S_WAIT) && !w_done_evt &&
                        (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign resp_error = r_resp_error;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt    <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_resp_error <= w_timeout;
            if (r_state == S_ISSUE)
                r_tmo_cnt <= '0;
            else if (r_state == S_WAIT && !w_timeout)
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign w_timeout  = (TIMEOUT_CYCLES < 0);
    assign resp_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_write      <= 1'b0;
            r_base       <= '0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_rdata      <= '0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_base      <= req_addr[ADDR_W-1:OFF_W];
                        r_wdata     <= req_wdata;
                        r_buf       <= '0;
                        r_idx       <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_addr  <= {r_base, r_idx, 2'b00};
                    r_mem_rw    <= r_write;
                    r_mem_wdata <= r_wdata[int'(r_idx)*DATA_W +: DATA_W];
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_evt) begin
                        if (!r_write)
                            r_buf <= w_buf_next;
                        if (w_last) begin
                            if (!r_write)
                                r_rdata <= w_buf_next;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_ISSUE;
                        end
                    end else if (w_timeout) begin
                        if (!r_write)
                            r_rdata <= r_buf;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready         = r_req_ready;
    assign busy              = r_busy;
    assign resp_valid        = r_resp_valid;
    assign resp_rdata        = r_rdata;
    assign mem_read_or_write = r_mem_rw;
    assign mem_address       = r_mem_addr;
    assign mem_write_data    = r_mem_wdata;
endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - self-checking bench for mem_burst_master with a word-array memory model
module tb_mem_burst_master;
    localparam int TMO = 64;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [9:0]   req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic         resp_error;
    logic         busy;
    logic         mem_read_or_write;
    logic [9:0]   mem_address;
    logic [31:0]  mem_write_data;
    logic         mem_done;
    logic [31:0]  mem_read_data;

    logic [31:0]  mem_arr [256];
    logic [31:0]  ref_arr [256];
    int checks = 0;
    int errors = 0;

    mem_burst_master #(.ADDR_W(10), .DATA_W(32), .WORDS(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .busy(busy), .mem_read_or_write(mem_read_or_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_done(mem_done), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_block(input logic [9:0] a);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = ref_arr[{a[9:4], 2'(k)}];
        return r;
    endfunction

    // Issues one block request and plays the memory for the first 'serve' words.
    task automatic run_block(input logic wr, input logic [9:0] addr, input logic [127:0] wd,
                             input int serve, input int bound, input logic hold,
                             output logic [127:0] got, output int pulses, output logic gerr);
        logic [7:0] wi;
        @(negedge clock);
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(negedge clock);
        if (!hold) req_valid = 1'b0;
        check("busy_after_accept", {busy, req_ready}, 2'b10);
        for (int k = 0; k < serve && k < 4; k++) begin
            repeat ($urandom_range(2, 5)) @(negedge clock);
            wi = {addr[9:4], 2'(k)};
            check("mem_address", mem_address, {addr[9:4], 2'(k), 2'b00});
            check("mem_rw", mem_read_or_write, wr);
            if (wr) begin
                check("mem_wdata", mem_write_data, wd[k*32 +: 32]);
                mem_arr[wi] = mem_write_data;
            end else begin
                mem_read_data = mem_arr[wi];
            end
            mem_done = 1'b1;
            repeat (2) @(negedge clock);
            mem_done = 1'b0;
        end
        pulses = 0; got = '0; gerr = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                pulses++; got = resp_rdata; gerr = resp_error; req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
    endtask

    logic [127:0] got, last, wd, expb;
    logic [9:0]   a, saved_addr;
    logic         e, wr;
    int           p, seen;

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_done = 1'b0; mem_read_data = '0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom; ref_arr[i] = mem_arr[i];
        end
        mem_arr[16] = 32'hCCCCCCCC; mem_arr[17] = 32'hEEEEEEEE;
        mem_arr[18] = 32'h55555555; mem_arr[19] = 32'hBBBBBBBB;
        mem_arr[64] = 32'h44444444; mem_arr[65] = 32'h33333333;
        mem_arr[66] = 32'h22222222; mem_arr[67] = 32'h11111111;
        for (int i = 0; i < 256; i++) ref_arr[i] = mem_arr[i];

        repeat (3) @(negedge clock);
        check("reset_ctrl", {req_ready, busy, resp_valid, resp_error, mem_read_or_write}, 5'b10000);
        check("reset_rdata", resp_rdata, '0);
        check("reset_mem", {mem_address, mem_write_data}, '0);
        reset_n = 1'b1;

        run_block(1'b0, 10'h040, '0, 4, 12, 1'b0, got, p, e);
        check("refill040_data", got, {32'hBBBBBBBB, 32'h55555555, 32'hEEEEEEEE, 32'hCCCCCCCC});
        check("refill040_pulses", p, 1);
        check("refill040_err", e, 0);

        run_block(1'b0, 10'h10C, '0, 4, 12, 1'b0, got, p, e);
        check("refill10C_data", got, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
        check("refill10C_pulses", p, 1);
        last = got;

        wd = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        for (int k = 0; k < 4; k++) ref_arr[8'hFC + k] = wd[k*32 +: 32];
        run_block(1'b1, 10'h3F0, wd, 4, 12, 1'b0, got, p, e);
        check("wb_pulses", p, 1);
        check("wb_rdata_kept", resp_rdata, last);
        check("wb_rw_held_idle", mem_read_or_write, 1);
        run_block(1'b0, 10'h3F0, '0, 4, 12, 1'b0, got, p, e);
        check("wb_readback", got, wd);
        check("readback_rw", mem_read_or_write, 0);
        last = got;

        saved_addr = mem_address;
        repeat (2) begin
            mem_done = 1'b1; repeat (3) @(negedge clock);
            mem_done = 1'b0; repeat (3) @(negedge clock);
            check("stray_done_idle", {busy, req_ready}, 2'b01);
        end
        check("stray_addr_stable", mem_address, saved_addr);
        a = 10'($urandom);
        run_block(1'b0, a, '0, 4, 12, 1'b1, got, p, e);
        check("held_single_pulse", p, 1);
        check("held_data", got, ref_block(a));
        check("held_no_reaccept", {busy, req_ready}, 2'b01);
        last = got;

        for (int n = 0; n < 8; n++) begin
            wr = 1'($urandom);
            a  = 10'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
            if (wr) for (int k = 0; k < 4; k++) ref_arr[{a[9:4], 2'(k)}] = wd[k*32 +: 32];
            run_block(wr, a, wd, 4, 12, 1'b0, got, p, e);
            check("rand_pulses", p, 1);
            if (wr) begin
                check("rand_wb_rdata_kept", resp_rdata, last);
            end else begin
                check("rand_refill", got, ref_block(a));
                last = got;
            end
        end

        a = 10'h2A0;
        run_block(1'b0, a, '0, 2, 3, 1'b0, got, p, e);
        check("midreset_no_resp_yet", p, 0);
        check("midreset_word2_addr", mem_address, {a[9:4], 2'd2, 2'b00});
        reset_n = 1'b0;
        #1;
        check("midreset_idle", {req_ready, busy, resp_valid}, 3'b100);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        check("midreset_no_pulse", seen, 0);
        run_block(1'b0, a, '0, 4, 12, 1'b0, got, p, e);
        check("postreset_refill", got, ref_block(a));
        check("postreset_pulses", p, 1);

`ifdef MEM_TIMEOUT_EN
        a = 10'h180;
        run_block(1'b0, a, '0, 2, TMO + 40, 1'b0, got, p, e);
        expb = ref_block(a);
        expb[127:64] = '0;
        check("timeout_pulses", p, 1);
        check("timeout_err", e, 1);
        check("timeout_data", got, expb);
`else
        check("no_timeout_err", resp_error, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
